punc_control_fsm: RTL and testbench



---
 rtl/punc_control_fsm.sv | 195 +++++++++++++++++++
 tb/tb_punc_control_fsm.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/punc_control_fsm.sv
// punc_control_fsm: multi-cycle control unit for the PUnC LC3 processor.
// Sequences INIT -> FETCH -> DECODE -> [IND] -> EXEC -> FETCH and drives every
// datapath select, load and write enable. Outputs are decoded from the current
// state and the instruction register.
// Optional build macro PUNC_CTRL_ILLEGAL_HALT_EN: opcodes 1000 and 1101 halt
// the machine instead of executing as NOP.
module punc_control_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic        pc_data_sel,
  output logic        ir_ld,
  output logic [1:0]  mem_addr_sel,
  output logic        mem_w_en,
  output logic [2:0]  rf_r_addr_0,
  output logic [2:0]  rf_r_addr_1,
  output logic [2:0]  rf_w_addr,
  output logic        rf_w_en,
  output logic [1:0]  rf_w_sel,
  output logic        a_sel,
  output logic        b_sel,
  output logic [1:0]  imm_sel,
  output logic [1:0]  alu_sel,
  output logic        nzp_sel,
  output logic        nzp_ld,
  output logic        store_ld,
  output logic        halted
);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_IND    = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] MA_PC = 2'b00, MA_ALU = 2'b01, MA_STORE = 2'b10;
  localparam logic [1:0] WS_PC = 2'b00, WS_MEM = 2'b01, WS_ALU = 2'b10;
  localparam logic [1:0] IMM5 = 2'b00, OFF6 = 2'b01, OFF9 = 2'b10, OFF11 = 2'b11;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_AND = 2'b01, ALU_NOT = 2'b11;

  logic [2:0] state_q, state_d;
  logic [3:0] opcode;
  logic [2:0] dr, sr1;
  logic       br_taken;
  logic       unused_ir_bits;

  assign opcode         = ir[15:12];
  assign dr             = ir[11:9];
  assign sr1            = ir[8:6];
  assign br_taken       = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
  assign unused_ir_bits = ^ir[4:3];

  // State register; reset forces INIT immediately, aborting any instruction.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, and the async reset sits in the sensitivity list.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_INIT;
    else      state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LDI, OP_STI: state_d = S_IND;
          OP_TRAP:        state_d = S_HALT;
`ifdef PUNC_CTRL_ILLEGAL_HALT_EN
          OP_RTI, OP_RES: state_d = S_HALT;
`endif
          default:        state_d = S_EXEC;
        endcase
      end
      S_IND:    state_d = S_EXEC;
      S_EXEC:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // Control outputs decoded from state and instruction.
  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_ld = 1'b0; pc_clr = 1'b0; pc_inc = 1'b0; pc_data_sel = 1'b0;
    ir_ld = 1'b0; mem_addr_sel = MA_PC; mem_w_en = 1'b0;
    rf_r_addr_0 = 3'd0; rf_r_addr_1 = 3'd0; rf_w_addr = 3'd0;
    rf_w_en = 1'b0; rf_w_sel = WS_PC; a_sel = 1'b0; b_sel = 1'b0;
    imm_sel = IMM5; alu_sel = ALU_ADD; nzp_sel = 1'b0; nzp_ld = 1'b0;
    store_ld = 1'b0; halted = 1'b0;
    case (state_q)
      S_INIT:  pc_clr = 1'b1;
      S_FETCH: begin
        mem_addr_sel = MA_PC; ir_ld = 1'b1; pc_inc = 1'b1;
      end
      S_IND: begin
        // Fetch the pointer at PC + off9 into the store register.
        mem_addr_sel = MA_ALU; b_sel = 1'b1; imm_sel = OFF9; store_ld = 1'b1;
      end
      S_EXEC: begin
        case (opcode)
          OP_ADD, OP_AND: begin
            a_sel = 1'b1; rf_r_addr_0 = sr1; rf_r_addr_1 = ir[2:0];
            b_sel = ir[5]; imm_sel = IMM5;
            alu_sel = (opcode == OP_AND) ? ALU_AND : ALU_ADD;
            rf_w_en = 1'b1; rf_w_addr = dr; rf_w_sel = WS_ALU; nzp_ld = 1'b1;
          end
          OP_NOT: begin
            a_sel = 1'b1; rf_r_addr_0 = sr1; alu_sel = ALU_NOT;
            rf_w_en = 1'b1; rf_w_addr = dr; rf_w_sel = WS_ALU; nzp_ld = 1'b1;
          end
          OP_BR: begin
            if (br_taken) begin
              b_sel = 1'b1; imm_sel = OFF9; pc_ld = 1'b1;
            end
          end
          OP_JMP: begin
            pc_data_sel = 1'b1; rf_r_addr_0 = sr1; pc_ld = 1'b1;
          end
          OP_JSR: begin
            // R7 and PC update on the same edge; R7 captures the incremented PC.
            rf_w_en = 1'b1; rf_w_addr = 3'd7; rf_w_sel = WS_PC; pc_ld = 1'b1;
            if (ir[11]) begin
              b_sel = 1'b1; imm_sel = OFF11;
            end else begin
              pc_data_sel = 1'b1; rf_r_addr_0 = sr1;
            end
          end
          OP_LD: begin
            b_sel = 1'b1; imm_sel = OFF9; mem_addr_sel = MA_ALU;
            rf_w_en = 1'b1; rf_w_addr = dr; rf_w_sel = WS_MEM;
            nzp_sel = 1'b1; nzp_ld = 1'b1;
          end
          OP_LDR: begin
            a_sel = 1'b1; rf_r_addr_0 = sr1; b_sel = 1'b1; imm_sel = OFF6;
            mem_addr_sel = MA_ALU;
            rf_w_en = 1'b1; rf_w_addr = dr; rf_w_sel = WS_MEM;
            nzp_sel = 1'b1; nzp_ld = 1'b1;
          end
          OP_LEA: begin
            b_sel = 1'b1; imm_sel = OFF9;
            rf_w_en = 1'b1; rf_w_addr = dr; rf_w_sel = WS_ALU;
          end
          OP_ST: begin
            b_sel = 1'b1; imm_sel = OFF9; mem_addr_sel = MA_ALU;
            rf_r_addr_1 = dr; mem_w_en = 1'b1;
          end
          OP_STR: begin
            a_sel = 1'b1; rf_r_addr_0 = sr1; b_sel = 1'b1; imm_sel = OFF6;
            mem_addr_sel = MA_ALU; rf_r_addr_1 = dr; mem_w_en = 1'b1;
          end
          OP_LDI: begin
            mem_addr_sel = MA_STORE;
            rf_w_en = 1'b1; rf_w_addr = dr; rf_w_sel = WS_MEM;
            nzp_sel = 1'b1; nzp_ld = 1'b1;
          end
          OP_STI: begin
            mem_addr_sel = MA_STORE; rf_r_addr_1 = dr; mem_w_en = 1'b1;
          end
          default: ;  // RTI/reserved execute as NOP when not halting
        endcase
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_punc_control_fsm.sv
// tb_punc_control_fsm: directed bench for punc_control_fsm. A behavioural
// model derives each instruction's phase sequence and required control word;
// a compare process checks the DUT every cycle, and literal checks pin the
// model at the points of interest.
module tb_punc_control_fsm;

  typedef enum int {P_INIT, P_FETCH, P_DECODE, P_IND, P_EXEC, P_HALT} phase_e;

  typedef struct packed {
    logic       pc_ld, pc_clr, pc_inc, pc_data_sel, ir_ld;
    logic [1:0] mem_addr_sel;
    logic       mem_w_en;
    logic [2:0] rf_r_addr_0, rf_r_addr_1, rf_w_addr;
    logic       rf_w_en;
    logic [1:0] rf_w_sel;
    logic       a_sel, b_sel;
    logic [1:0] imm_sel, alu_sel;
    logic       nzp_sel, nzp_ld, store_ld, halted;
  } ctl_t;

  logic clk, rst, n, z, p;
  logic [15:0] ir;
  ctl_t dut;
  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  punc_control_fsm u_dut (
    .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
    .pc_ld(dut.pc_ld), .pc_clr(dut.pc_clr), .pc_inc(dut.pc_inc),
    .pc_data_sel(dut.pc_data_sel), .ir_ld(dut.ir_ld),
    .mem_addr_sel(dut.mem_addr_sel), .mem_w_en(dut.mem_w_en),
    .rf_r_addr_0(dut.rf_r_addr_0), .rf_r_addr_1(dut.rf_r_addr_1),
    .rf_w_addr(dut.rf_w_addr), .rf_w_en(dut.rf_w_en), .rf_w_sel(dut.rf_w_sel),
    .a_sel(dut.a_sel), .b_sel(dut.b_sel), .imm_sel(dut.imm_sel),
    .alu_sel(dut.alu_sel), .nzp_sel(dut.nzp_sel), .nzp_ld(dut.nzp_ld),
    .store_ld(dut.store_ld), .halted(dut.halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit halts(input logic [3:0] op);
`ifdef PUNC_CTRL_ILLEGAL_HALT_EN
    return op == 4'hF || op == 4'h8 || op == 4'hD;
`else
    return op == 4'hF;
`endif
  endfunction

  function automatic bit indirect(input logic [3:0] op);
    return op == 4'hA || op == 4'hB;
  endfunction

  // Phase list of an instruction: FETCH, DECODE, then IND/EXEC/HALT.
  function automatic int path_len(input logic [15:0] i);
    return indirect(i[15:12]) ? 4 : 3;
  endfunction

  function automatic phase_e path_at(input logic [15:0] i, input int idx);
    if (idx == 0) return P_FETCH;
    if (idx == 1) return P_DECODE;
    if (idx == 3) return P_EXEC;
    if (indirect(i[15:12])) return P_IND;
    return halts(i[15:12]) ? P_HALT : P_EXEC;
  endfunction

  // ALU computes PC + sign-extended immediate field.
  function automatic ctl_t pc_rel(input ctl_t c, input logic [1:0] imm);
    c.a_sel = 0; c.b_sel = 1; c.imm_sel = imm; c.alu_sel = 2'b00;
    return c;
  endfunction

  // ALU computes BaseR + off6.
  function automatic ctl_t base_rel(input ctl_t c, input logic [2:0] base);
    c.a_sel = 1; c.rf_r_addr_0 = base; c.b_sel = 1; c.imm_sel = 2'b01;
    return c;
  endfunction

  // Register write of a given source, optionally loading flags from it.
  function automatic ctl_t wr(input ctl_t c, input logic [2:0] d,
                              input logic [1:0] src, input bit flags);
    c.rf_w_en = 1; c.rf_w_addr = d; c.rf_w_sel = src;
    if (flags) begin
      c.nzp_ld = 1; c.nzp_sel = (src == 2'b01);
    end
    return c;
  endfunction

  function automatic ctl_t exp_out(input phase_e ph, input logic [15:0] i,
                                   input logic nn, input logic zz, input logic pp);
    ctl_t c = '0;
    logic [3:0] op = i[15:12];
    logic [2:0] d = i[11:9];
    logic [2:0] b = i[8:6];
    case (ph)
      P_INIT:  c.pc_clr = 1;
      P_FETCH: begin c.ir_ld = 1; c.pc_inc = 1; end
      P_IND:   begin c = pc_rel(c, 2'b10); c.mem_addr_sel = 2'b01; c.store_ld = 1; end
      P_HALT:  c.halted = 1;
      P_EXEC: begin
        case (op)
          4'h1, 4'h5: begin
            c.a_sel = 1; c.rf_r_addr_0 = b; c.rf_r_addr_1 = i[2:0]; c.b_sel = i[5];
            c.alu_sel = (op == 4'h5) ? 2'b01 : 2'b00;
            c = wr(c, d, 2'b10, 1);
          end
          4'h9: begin
            c.a_sel = 1; c.rf_r_addr_0 = b; c.alu_sel = 2'b11; c = wr(c, d, 2'b10, 1);
          end
          4'h0: if ((i[11] && nn) || (i[10] && zz) || (i[9] && pp)) begin
            c = pc_rel(c, 2'b10); c.pc_ld = 1;
          end
          4'hC: begin c.pc_data_sel = 1; c.rf_r_addr_0 = b; c.pc_ld = 1; end
          4'h4: begin
            c = wr(c, 3'd7, 2'b00, 0); c.pc_ld = 1;
            if (i[11]) c = pc_rel(c, 2'b11);
            else begin c.pc_data_sel = 1; c.rf_r_addr_0 = b; end
          end
          4'h2: begin c = pc_rel(c, 2'b10); c.mem_addr_sel = 2'b01; c = wr(c, d, 2'b01, 1); end
          4'h6: begin c = base_rel(c, b); c.mem_addr_sel = 2'b01; c = wr(c, d, 2'b01, 1); end
          4'hE: begin c = pc_rel(c, 2'b10); c = wr(c, d, 2'b10, 0); end
          4'h3: begin
            c = pc_rel(c, 2'b10); c.mem_addr_sel = 2'b01; c.rf_r_addr_1 = d; c.mem_w_en = 1;
          end
          4'h7: begin
            c = base_rel(c, b); c.mem_addr_sel = 2'b01; c.rf_r_addr_1 = d; c.mem_w_en = 1;
          end
          4'hA: begin c.mem_addr_sel = 2'b10; c = wr(c, d, 2'b01, 1); end
          4'hB: begin c.mem_addr_sel = 2'b10; c.rf_r_addr_1 = d; c.mem_w_en = 1; end
          default: ;
        endcase
      end
      default: ;
    endcase
    return c;
  endfunction

  bit m_init = 1;
  int m_idx  = 0;
  phase_e m_phase;
  assign m_phase = m_init ? P_INIT : path_at(ir, m_idx);

  // Model position within the current instruction.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_init <= 1; m_idx <= 0;
    end else if (m_init) begin
      m_init <= 0; m_idx <= 0;
    end else if (m_phase != P_HALT) begin
      m_idx <= (m_idx + 1 == path_len(ir)) ? 0 : m_idx + 1;
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) check($sformatf("cycle_%s", m_phase.name()), 32'(dut),
                      32'(exp_out(m_phase, ir, n, z, p)));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one instruction from FETCH and measure cycles until the next FETCH.
  task automatic run_instr(input logic [15:0] instr, input logic [2:0] nzp_v,
                           input int exp_lat);
    int cyc = 0;
    ir = instr; {n, z, p} = nzp_v;
    do begin step(); cyc++; end while (!dut.ir_ld && cyc < 8);
    check($sformatf("latency_%h", instr), cyc, exp_lat);
  endtask

  typedef struct { logic [15:0] instr; logic [2:0] nzp; int lat; } vec_t;
  vec_t vecs[$];
  ctl_t lit;

  initial begin
    rst = 0; ir = 16'h0000; {n, z, p} = 3'b000;
    step(); step();
    cmp_en = 1;
    lit = '0; lit.pc_clr = 1;
    check("reset_state", 32'(dut), 32'(lit));
    rst = 1;
    check("init_after_release", dut.pc_clr, 1);
    step();
    check("fetch_ir_ld", dut.ir_ld, 1);
    check("fetch_pc_inc", dut.pc_inc, 1);
    check("fetch_mem_addr_sel", dut.mem_addr_sel, 0);

    // ADD R1, R1, #1
    ir = 16'h1261; step(); step();
    check("add_b_sel", dut.b_sel, 1);
    check("add_imm_sel", dut.imm_sel, 0);
    check("add_alu_sel", dut.alu_sel, 0);
    check("add_rf_w_addr", dut.rf_w_addr, 1);
    check("add_rf_w_en", dut.rf_w_en, 1);
    check("add_nzp_ld", dut.nzp_ld, 1);
    step();
    check("add_back_to_fetch", dut.ir_ld, 1);

    // BRz taken, then not taken
    ir = 16'h0402; {n, z, p} = 3'b010; step(); step();
    check("brz_taken_pc_ld", dut.pc_ld, 1);
    step();
    check("brz_taken_next_fetch", dut.ir_ld, 1);
    {n, z, p} = 3'b100; step(); step();
    check("brz_not_taken_pc_ld", dut.pc_ld, 0);
    step();
    check("brz_not_taken_next_fetch", dut.ir_ld, 1);

    // LDI R1
    ir = 16'hA203; step();
    check("ldi_decode_quiet", 32'(dut), 0);
    step();
    check("ldi_ind_store_ld", dut.store_ld, 1);
    step();
    check("ldi_exec_mem_addr_sel", dut.mem_addr_sel, 2);
    check("ldi_exec_rf_w_sel", dut.rf_w_sel, 1);
    step();
    check("ldi_next_fetch", dut.ir_ld, 1);

    // Directed sweep of every opcode family.
    vecs = '{
      '{16'h1042, 3'b000, 3}, '{16'h5A7F, 3'b000, 3}, '{16'h5A82, 3'b000, 3},
      '{16'h967F, 3'b000, 3}, '{16'h0E05, 3'b001, 3}, '{16'h0805, 3'b010, 3},
      '{16'hC1C0, 3'b000, 3}, '{16'h4805, 3'b000, 3}, '{16'h4080, 3'b000, 3},
      '{16'h2205, 3'b000, 3}, '{16'h6A46, 3'b000, 3}, '{16'hE405, 3'b000, 3},
      '{16'h3605, 3'b000, 3}, '{16'h7AC3, 3'b000, 3}, '{16'hB405, 3'b000, 4},
      '{16'hA9FF, 3'b100, 4}
    };
    foreach (vecs[k]) run_instr(vecs[k].instr, vecs[k].nzp, vecs[k].lat);
`ifndef PUNC_CTRL_ILLEGAL_HALT_EN
    run_instr(16'h8000, 3'b000, 3);
`endif

    // Reset asserted mid-instruction (STI in IND) aborts at once.
    ir = 16'hB405; step(); step();
    check("sti_ind_store_ld", dut.store_ld, 1);
    #2 rst = 0; #1;
    lit = '0; lit.pc_clr = 1;
    check("midreset_async_init", 32'(dut), 32'(lit));
    step(); rst = 1; step();
    check("midreset_recover_fetch", dut.ir_ld, 1);

    // Opcode 1101: halt or NOP depending on build.
    ir = 16'hD000; step(); step();
`ifdef PUNC_CTRL_ILLEGAL_HALT_EN
    check("d000_halted", dut.halted, 1);
    rst = 0; step(); rst = 1; step();
    check("d000_reset_fetch", dut.ir_ld, 1);
`else
    check("d000_exec_zero", 32'(dut), 0);
    step();
    check("d000_next_fetch", dut.ir_ld, 1);
`endif

    // TRAP halts until reset.
    ir = 16'hF025; step(); step();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("trap_halted_%0d", k), dut.halted, 1);
      step();
    end
    rst = 0; #1;
    check("trap_reset_pc_clr", dut.pc_clr, 1);
    check("trap_reset_halted", dut.halted, 0);
    step(); rst = 1; step();
    check("trap_reset_fetch", dut.ir_ld, 1);

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
